// File: rtl/clk_step_ctrl_pkg.sv
// Shared definitions for the TD4 clock/step controller: FSM state
// encodings (also read by the LED and display blocks) and the helper
// that turns a divider into its prescaler compare limit.
package clk_step_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_BAD  = 2'd3   // never entered; recovers to ST_STOP
    } state_t;

    // Prescaler compare value for the selected speed: a divider of N
    // means the counter runs 0..N-1, so the limit is N-1.
    function automatic int unsigned sel_limit(
        input logic        fast,
        input int unsigned slow_div,
        input int unsigned fast_div
    );
        return (fast ? fast_div : slow_div) - 1;
    endfunction

endpackage

// File: rtl/clk_step_ctrl_ce_prescaler.sv
// Free-running prescaler for RUN mode. tick is the combinational
// compare result; the caller registers it into the CPU clock enable.
// The counter sits at zero whenever it is cleared or not enabled.
module ce_prescaler #(
    parameter int CNT_W = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tick
);

    logic [CNT_W-1:0] count_reg;

    // >= rather than == so that lowering the limit below the current
    // count fires immediately instead of running all the way round.
    assign tick = en && (count_reg >= limit);

    // Count while enabled, restart from zero after each tick.
    always_ff @(posedge CLK) begin
        if (!RST || clr || !en) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/stop/single-step clock-enable controller for the TD4 CPU.
// step_pulse and run_pulse arrive already debounced and one-shot.
// cpu_ce is registered, so every enable appears the cycle after the
// condition that caused it.
module clk_step_ctrl
    import clk_step_ctrl_pkg::*;
#(
    parameter int unsigned SLOW_DIV = 12_000_000,
    parameter int unsigned FAST_DIV = 1_200_000,
    parameter int          CNT_W    = 24
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         step_pulse,
    input  logic         run_pulse,
    input  logic         speed_sel,
    input  logic         halt_req,
    output logic         cpu_ce,
    output logic [1:0]   state,
    output logic [7:0]   ce_count
);

    state_t             state_reg;
    state_t             state_next;
    logic               cpu_ce_reg;
    logic               ce_next;
    logic [7:0]         ce_count_reg;
    logic               presc_clr;
    logic               presc_en;
    logic               presc_tick;
    logic [CNT_W-1:0]   presc_limit;

    assign presc_limit = CNT_W'(sel_limit(speed_sel, SLOW_DIV, FAST_DIV));

    ce_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (presc_clr),
        .en    (presc_en),
        .limit (presc_limit),
        .tick  (presc_tick)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg <= ST_STOP;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: halt wins over everything; run_pulse toggles run/stop
    // and is the only way out of HALT once halt_req has dropped.
    always_comb begin
        state_next = ST_STOP;
        if (state_reg == ST_BAD) begin
            state_next = ST_STOP;
        end else if (halt_req) begin
            state_next = ST_HALT;
        end else begin
            case (state_reg)
                ST_STOP: state_next = run_pulse ? ST_RUN  : ST_STOP;
                ST_RUN:  state_next = run_pulse ? ST_STOP : ST_RUN;
                ST_HALT: state_next = run_pulse ? ST_STOP : ST_HALT;
                default: state_next = ST_STOP;
            endcase
        end
    end

    // Outputs: prescaler control and the next clock enable. A step is
    // refused while an enable is already out so two steps in a row
    // cannot produce back-to-back enables.
    always_comb begin
        presc_en  = 1'b0;
        presc_clr = 1'b1;
        ce_next   = 1'b0;
        case (state_reg)
            ST_STOP: begin
                ce_next = step_pulse && !run_pulse && !halt_req && !cpu_ce_reg;
            end
            ST_RUN: begin
                presc_en  = 1'b1;
                presc_clr = run_pulse || halt_req;
                ce_next   = presc_tick && !run_pulse && !halt_req;
            end
            default: begin
                ce_next = 1'b0;
            end
        endcase
    end

    // Registered clock enable and the pulse counter that tracks it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cpu_ce_reg   <= 1'b0;
            ce_count_reg <= 8'd0;
        end else begin
            cpu_ce_reg <= ce_next;
            if (ce_next) begin
                ce_count_reg <= ce_count_reg + 8'd1;
            end
        end
    end

    assign cpu_ce   = cpu_ce_reg;
    assign state    = state_reg;
    assign ce_count = ce_count_reg;

endmodule
